// File: rtl/rectifier_stream.sv
`default_nettype none
// ============================================================================
// Module   : rectifier_stream
// Purpose  : Frame-based rectifier for signed sample streams with valid/ready
//            handshakes, an output FIFO and an end-of-frame stop pulse.
//            Define RECTIFIER_PEAK_EN to add per-frame peak tracking outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rectifier_stream #(
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 42,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     send_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     stop,
  output logic                     busy
`ifdef RECTIFIER_PEAK_EN
  ,
  output logic [DATA_W-1:0]        peak_data,
  output logic                     peak_valid
`endif
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]        FULL_CNT  = CNT_W'(NUM_SAMPLES);
  localparam logic [OCC_W-1:0]        DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic signed [DATA_W-1:0] MIN_S    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]       MAX_U     = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               send_data_q, send_data_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;

  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  push_val;

  // |x| saturates at the most negative input, which has no positive twin.
  function automatic logic [DATA_W-1:0] rectify(input logic [1:0] m,
                                                input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] res;
    if (x == MIN_S)          mag = MAX_U;
    else if (x[DATA_W-1])    mag = -x;
    else                     mag = x;
    case (m)
      2'b00:   res = x;
      2'b01:   res = x[DATA_W-1] ? '0 : x;
      2'b10:   res = mag;
      default: res = x[DATA_W-1] ? mag : '0;
    endcase
    return res;
  endfunction

  assign push     = in_valid && send_data_q;
  assign pop      = out_valid_q && out_ready;
  assign push_val = rectify(mode_q, in_data);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_d     = mode_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    out_data_d = out_data_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_val;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          count_d = '0;
        end
      end
      RUN:     if (push && (count_q == LAST_CNT)) state_d = DRAIN;
      DRAIN:   if (occ_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Head register tracks the next-cycle head so it already includes a
    // same-cycle push into an empty FIFO; it holds when the FIFO drains.
    if (occ_d != '0) out_data_d = mem_d[rd_ptr_d];

    send_data_d = (state_d == RUN) && (occ_d != DEPTH_OCC) && (count_d < FULL_CNT);
    out_valid_d = (occ_d != '0);
    stop_d      = (state_d == DONE);
    busy_d      = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mode_q      <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      send_data_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      send_data_q <= send_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign send_data = send_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stop      = stop_q;
  assign busy      = busy_q;

`ifdef RECTIFIER_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              peak_valid_q, peak_valid_d;

  // Peak only moves while samples are accepted, so it is frozen from DONE
  // until the next accepted start clears it.
  always_comb begin
    peak_d = peak_q;
    if ((state_q == IDLE) && start)            peak_d = '0;
    else if (push && (push_val > peak_q))      peak_d = push_val;
    peak_valid_d = stop_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_q       <= peak_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign peak_data  = peak_q;
  assign peak_valid = peak_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rectifier_stream.sv
`default_nettype none
// Directed testbench for rectifier_stream: a 4-sample instance (u_dut4) and a
// 42-sample instance (u_dut42) share clock and reset.
module tb_rectifier_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start     [2];
  logic [1:0]  mode      [2];
  logic        in_valid  [2];
  logic [15:0] in_data   [2];
  logic        send_data [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic        stop      [2];
  logic        busy      [2];
`ifdef RECTIFIER_PEAK_EN
  logic [15:0] peak_data [2];
  logic        peak_valid[2];
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cnt  [2];
  int          stop_cnt [2];
  int          accq[$];
  bit          lat_chk  = 1'b0;
  bit          bp_done  = 1'b0;
  logic [15:0] outq0[$];
  logic [15:0] outq1[$];
  logic [15:0] smp [64];
  logic [15:0] expv[64];

  always #5 clk = ~clk;

  rectifier_stream #(.DATA_W(16), .NUM_SAMPLES(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .send_data(send_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .stop(stop[0]), .busy(busy[0])
`ifdef RECTIFIER_PEAK_EN
    , .peak_data(peak_data[0]), .peak_valid(peak_valid[0])
`endif
  );

  rectifier_stream #(.DATA_W(16), .NUM_SAMPLES(42), .FIFO_DEPTH(4)) u_dut42 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .send_data(send_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .stop(stop[1]), .busy(busy[1])
`ifdef RECTIFIER_PEAK_EN
    , .peak_data(peak_data[1]), .peak_valid(peak_valid[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rect(input logic [1:0] m, input logic [15:0] x);
    logic [15:0] a;
    if (x == 16'h8000)  a = 16'h7FFF;
    else if (x[15])     a = 16'(0 - int'($signed(x)));
    else                a = x;
    case (m)
      2'b00:   return x;
      2'b01:   return x[15] ? 16'h0000 : x;
      2'b10:   return a;
      default: return x[15] ? a : 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (out_valid[0] && out_ready[0]) begin
      outq0.push_back(out_data[0]);
      if (lat_chk && accq.size() > 0) check("out_latency", cyc - accq.pop_front(), 1);
    end
    if (out_valid[1] && out_ready[1]) outq1.push_back(out_data[1]);
    if (in_valid[0] && send_data[0]) begin
      acc_cnt[0]++;
      accq.push_back(cyc);
    end
    if (in_valid[1] && send_data[1]) acc_cnt[1]++;
    if (stop[0]) stop_cnt[0]++;
    if (stop[1]) stop_cnt[1]++;
  end

  task automatic clear_obs(input int s);
    if (s == 0) begin outq0.delete(); accq.delete(); end
    else        outq1.delete();
    acc_cnt[s] = 0;
  endtask

  task automatic run_frame(input int s, input logic [1:0] m, input int n,
                           input bit tog, input int abort_at);
    int guard;
    int stops0;
    stops0 = stop_cnt[s];
    @(posedge clk); #1;
    start[s] = 1'b1;
    mode[s]  = m;
    @(posedge clk); #1;
    start[s] = 1'b0;
    check("busy_in_run", busy[s], 1);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        in_valid[s] = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_send_data", send_data[s], 0);
        check("rst_out_valid", out_valid[s], 0);
        check("rst_out_data", out_data[s], 0);
        check("rst_stop", stop[s], 0);
        check("rst_busy", busy[s], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_stop", stop_cnt[s], stops0);
        return;
      end
      in_valid[s] = 1'b1;
      in_data[s]  = smp[k];
      if (tog && k == 5) begin start[s] = 1'b1; mode[s] = ~m; end
      if (tog && k == 9) start[s] = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!send_data[s] && guard < 1000) begin guard++; @(negedge clk); end
      if (guard >= 1000) begin check("accept_timeout", guard, 0); break; end
      @(posedge clk); #1;
    end
    in_valid[s] = 1'b0;
    start[s]    = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!stop[s] && guard < 2000) begin guard++; @(negedge clk); end
    check("stop_pulse", stop[s], 1);
    check("busy_in_done", busy[s], 0);
`ifdef RECTIFIER_PEAK_EN
    check("peak_valid_with_stop", peak_valid[s], 1);
`endif
    @(negedge clk);
    check("stop_one_cycle", stop[s], 0);
    check("stop_count", stop_cnt[s], stops0 + 1);
  endtask

  task automatic check_outs(input int s, input int n);
    int sz;
    sz = (s == 0) ? outq0.size() : outq1.size();
    check($sformatf("out_count_s%0d", s), sz, n);
    for (int k = 0; k < n && k < sz; k++)
      check($sformatf("out%0d_s%0d", k, s), (s == 0) ? outq0[k] : outq1[k], expv[k]);
  endtask

  task automatic fill42(input logic [1:0] m);
    for (int k = 0; k < 42; k++) smp[k] = 16'(k * 2731 - 30000);
    smp[3]  = 16'h8000;
    smp[7]  = 16'h7FFF;
    smp[11] = 16'h0000;
    smp[12] = 16'hFFFF;
    for (int k = 0; k < 42; k++) expv[k] = rect(m, smp[k]);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = 2'b00; in_valid[i] = 1'b0;
      in_data[i] = '0; out_ready[i] = 1'b1; acc_cnt[i] = 0; stop_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_send_data", send_data[0], 0);
    check("reset_out_valid", out_valid[1], 0);
    check("reset_out_data", out_data[0], 0);
    check("reset_stop", stop[1], 0);
    check("reset_busy", busy[0], 0);
`ifdef RECTIFIER_PEAK_EN
    check("reset_peak_data", peak_data[0], 0);
    check("reset_peak_valid", peak_valid[0], 0);
`endif
    rst_n = 1'b1;

    // in_valid while idle is not accepted
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_send_data", send_data[0], 0);
    check("idle_no_accept", acc_cnt[0], 0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;

    // Full-wave, 4 samples, with saturation of -32768
    clear_obs(0);
    smp[0] = 16'd100; smp[1] = 16'hFF9C; smp[2] = 16'h8000; smp[3] = 16'd0;
    expv[0] = 16'd100; expv[1] = 16'd100; expv[2] = 16'h7FFF; expv[3] = 16'd0;
    lat_chk = 1'b1;
    run_frame(0, 2'b10, 4, 1'b0, -1);
    lat_chk = 1'b0;
    check_outs(0, 4);

    // Half-wave
    clear_obs(0);
    smp[0] = 16'd5; smp[1] = 16'hFFFB; smp[2] = 16'd7; smp[3] = 16'hFFFF;
    expv[0] = 16'd5; expv[1] = 16'd0; expv[2] = 16'd7; expv[3] = 16'd0;
    run_frame(0, 2'b01, 4, 1'b0, -1);
    check_outs(0, 4);

    // Negative half-wave
    clear_obs(0);
    expv[0] = 16'd0; expv[1] = 16'd5; expv[2] = 16'd0; expv[3] = 16'd1;
    run_frame(0, 2'b11, 4, 1'b0, -1);
    check_outs(0, 4);

    // Pass-through reinterprets as unsigned
    clear_obs(0);
    smp[0] = 16'hFFFF; smp[1] = 16'h7FFF; smp[2] = 16'h8000; smp[3] = 16'h0001;
    expv[0] = 16'hFFFF; expv[1] = 16'h7FFF; expv[2] = 16'h8000; expv[3] = 16'h0001;
    run_frame(0, 2'b00, 4, 1'b0, -1);
    check_outs(0, 4);

    // Backpressure on a 42-sample frame
    clear_obs(1);
    fill42(2'b10);
    out_ready[1] = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        run_frame(1, 2'b10, 42, 1'b0, -1);
        bp_done = 1'b1;
      end
      begin
        repeat (12) @(negedge clk);
        check("bp_accepts", acc_cnt[1], 4);
        check("bp_send_data_full", send_data[1], 0);
        check("bp_out_valid", out_valid[1], 1);
        check("bp_head", out_data[1], expv[0]);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        check("bp_send_data_after_pop", send_data[1], 1);
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready[1] = 1'($urandom_range(0, 1));
        end
        out_ready[1] = 1'b1;
      end
    join
    check("bp_total_accepts", acc_cnt[1], 42);
    check_outs(1, 42);

    // Reset after 10 of 42 samples, then a fresh frame
    clear_obs(1);
    fill42(2'b10);
    run_frame(1, 2'b10, 42, 1'b0, 10);
    @(posedge clk); #1;
    clear_obs(1);
    run_frame(1, 2'b10, 42, 1'b0, -1);
    check("post_reset_accepts", acc_cnt[1], 42);
    check_outs(1, 42);

    // start/mode toggling during RUN is ignored
    clear_obs(1);
    fill42(2'b01);
    run_frame(1, 2'b01, 42, 1'b1, -1);
    check("toggle_accepts", acc_cnt[1], 42);
    check_outs(1, 42);

`ifdef RECTIFIER_PEAK_EN
    clear_obs(0);
    smp[0] = 16'd3; smp[1] = 16'hFFF7; smp[2] = 16'd4; smp[3] = 16'd2;
    run_frame(0, 2'b10, 4, 1'b0, -1);
    check("peak_frame1", peak_data[0], 16'd9);
    repeat (3) @(negedge clk);
    check("peak_held", peak_data[0], 16'd9);
    clear_obs(0);
    smp[0] = 16'd1; smp[1] = 16'd1; smp[2] = 16'd1; smp[3] = 16'd1;
    run_frame(0, 2'b10, 4, 1'b0, -1);
    check("peak_frame2", peak_data[0], 16'd1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rectifier_stream.md
Name: rectifier_stream

Overview:
Frame-based streaming rectifier for signed sample streams, such as sinusoid test vectors.
- Per-frame mode: pass, half-wave, full-wave or negative half-wave.
- Each frame has a fixed sample count.
- Valid/ready handshake on both sides, with a small output FIFO for backpressure.
- Pulses `stop` when a frame has fully drained. Sits between a sample source (file reader or ADC front end) and downstream DSP/logging.

Parameters:
DATA_W, 16, sample width in bits (signed in, unsigned out)
NUM_SAMPLES, 42, samples per frame (>=1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start request; sampled only in IDLE
mode  input  2  00 pass, 01 half-wave, 10 full-wave, 11 negative half-wave; latched on accepted start
in_valid  input  1  in_data valid
in_data  input  DATA_W  signed input sample
send_data  output  1  input ready; a sample is accepted when in_valid && send_data
out_valid  output  1  out_data valid (FIFO head)
out_ready  input  1  downstream accepts out_data when out_valid && out_ready
out_data  output  DATA_W  unsigned rectified sample
stop  output  1  one-cycle pulse when a frame completes
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state=IDLE; sample count=0; FIFO empty.
  - send_data=0, out_valid=0, out_data=0, stop=0, busy=0, latched mode=00.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start=1. Latch mode; clear count.
  - RUN -> DRAIN on the cycle the NUM_SAMPLES-th sample is accepted.
  - DRAIN -> DONE when the FIFO is empty, including an empty condition reached by a pop in the same cycle.
  - DONE -> IDLE unconditionally. stop=1 only during the DONE cycle.
- send_data = (state==RUN) && !fifo_full && (count < NUM_SAMPLES). It is a registered-state function only: no combinational path from out_ready.
- Rectification of input x, applied on acceptance:
  - mode 00: out = x reinterpreted as unsigned bits.
  - mode 01: out = (x<0) ? 0 : x.
  - mode 10: out = |x|.
  - mode 11: out = (x<0) ? |x| : 0.
  - |x| of the most negative value (-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1.
- Latency: the rectified sample is written to the FIFO on the accept edge. out_valid rises the next cycle when the FIFO was empty (1-cycle latency).
- FIFO boundaries:
  - Simultaneous push and pop when full is impossible, because send_data=0 when full.
  - Simultaneous push and pop when non-empty keeps occupancy constant.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data holds the FIFO head; when empty it holds its last value (0 after reset).
- mode and start changes during RUN, DRAIN or DONE are ignored. start during DONE is ignored (it is re-sampled in IDLE).
- in_valid outside RUN is ignored; nothing is accepted.
- Reset mid-frame: immediate return to IDLE and FIFO flush. No stop pulse is generated.
- Count width is clog2(NUM_SAMPLES+1). NUM_SAMPLES=1 is legal: RUN lasts until the first accept.

Optional Feature:
RECTIFIER_PEAK_EN
- With the macro defined:
  - Extra outputs `peak_data` (DATA_W) and `peak_valid` (1).
  - A register tracks the maximum rectified value accepted during the current frame. It clears to 0 on frame start.
  - `peak_data` is held stable from DONE until the next frame start. `peak_valid` pulses with `stop`.
  - Both are reset to 0.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then start with mode=10 and NUM_SAMPLES=4. Inputs 100, -100, -32768, 0, with out_ready=1 -> out_data 100, 100, 32767, 0, each one cycle after its accept. stop pulses once after the last output. busy drops with DONE.
2. mode=01 with inputs 5, -5, 7, -1 -> outputs 5, 0, 7, 0. mode=11 with the same inputs -> 0, 5, 0, 1. mode=00 with input -1 -> 0xFFFF.
3. Backpressure: out_ready=0, in_valid=1 constantly, FIFO_DEPTH=4 -> exactly 4 accepts, then send_data=0. Raise out_ready for 1 cycle -> one pop, and send_data returns 1 the next cycle. No sample is lost or duplicated across the full 42-sample frame.
4. Assert rst_n=0 after 10 of 42 samples -> all outputs 0 asynchronously, no stop pulse. A new start afterwards yields a fresh 42-sample frame.
5. Toggle start and mode mid-RUN -> no effect; the frame uses the latched mode and the count is still exactly 42.
6. (RECTIFIER_PEAK_EN) mode=10 with inputs 3, -9, 4, 2 -> peak_data=9 with peak_valid coincident with stop. The next frame (inputs 1, 1, 1, 1) -> peak_data=1.
